dff_delay_line: RTL and testbench

Parametrised register delay line, the multi-stage successor of the single-stage WIDTH-bit D flip-flop. Holds DEPTH stages of WIDTH-bit data, each with a valid bit. Adds clock enable (stall), flush, synchronous reset, a runtime-selectable tap and an occupancy count. Used wherever a datapath needs a fixed or selectable latency with stall support.

---
 rtl/dff_delay_line.sv | 120 ++++++++++++
 tb/tb_dff_delay_line.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dff_delay_line.sv
// Multi-stage WIDTH-bit register delay line with per-stage valid bits, stall,
// flush, a runtime-selectable output tap and a registered occupancy count.

module dff_delay_stage #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_v,
    output logic [WIDTH-1:0] o_d,
    output logic             o_v
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Data keeps shifting under flush; only the valid qualifier is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= RESET_VALUE;
            r_valid <= 1'b0;
        end else begin
            if (i_en)
                r_data <= i_d;
            if (i_flush)
                r_valid <= 1'b0;
            else if (i_en)
                r_valid <= i_v;
        end
    end

    assign o_d = r_data;
    assign o_v = r_valid;
endmodule

module dff_delay_line #(
    parameter int               WIDTH       = 4,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              SW          = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
    localparam int              CW          = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             VALID_IN,
    input  logic [SW-1:0]    SEL,
    output logic [WIDTH-1:0] Q,
    output logic             VALID_OUT,
    output logic [WIDTH-1:0] Q_LAST,
    output logic             VALID_LAST,
    output logic [CW-1:0]    OCCUPANCY
);
    logic [DEPTH-1:0][WIDTH-1:0] w_d_in;
    logic [DEPTH-1:0]            w_v_in;
    logic [DEPTH-1:0][WIDTH-1:0] w_data;
    logic [DEPTH-1:0]            w_valid;
    logic [CW-1:0]               r_occ;
    logic [WIDTH-1:0]            w_q;
    logic                        w_vout;

    assign w_d_in[0] = D;
    assign w_v_in[0] = VALID_IN;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g > 0) begin : g_link
            assign w_d_in[g] = w_data[g-1];
            assign w_v_in[g] = w_valid[g-1];
        end
        dff_delay_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_en    (EN),
            .i_flush (FLUSH),
            .i_d     (w_d_in[g]),
            .i_v     (w_v_in[g]),
            .o_d     (w_data[g]),
            .o_v     (w_valid[g])
        );
    end

    // Tracked incrementally so OCCUPANCY stays a pure register output.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            r_occ <= '0;
        end else if (EN) begin
            case ({VALID_IN, w_valid[DEPTH-1]})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Out-of-range taps (non power-of-two DEPTH) fall through to the defaults.
    always_comb begin
        w_q    = RESET_VALUE;
        w_vout = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(SEL) == i) begin
                w_q    = w_data[i];
                w_vout = w_valid[i];
            end
        end
    end

    assign Q          = w_q;
    assign VALID_OUT  = w_vout;
    assign Q_LAST     = w_data[DEPTH-1];
    assign VALID_LAST = w_valid[DEPTH-1];
    assign OCCUPANCY  = r_occ;
endmodule

// File: tb/tb_dff_delay_line.sv
// Bench for dff_delay_line: vector table plus an in-order scoreboard on the last
// stage for a DEPTH=4 instance, and a tap-select check on a DEPTH=3 instance.

module tb_dff_delay_line;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4, RESET_VALUE=0
    logic       rst = 1'b1, en = 1'b0, flush = 1'b0, vin = 1'b0;
    logic [3:0] d = 4'h0;
    logic [1:0] sel = 2'd0;
    logic [3:0] q, q_last;
    logic       vout, vlast;
    logic [2:0] occ;

    // DEPTH=3, RESET_VALUE=C so the out-of-range tap is distinguishable
    logic       rst3 = 1'b1, en3 = 1'b0, flush3 = 1'b0, vin3 = 1'b0;
    logic [3:0] d3 = 4'h0;
    logic [1:0] sel3 = 2'd0;
    logic [3:0] q3, q_last3;
    logic       vout3, vlast3;
    logic [1:0] occ3;

    dff_delay_line #(.WIDTH(4), .DEPTH(4), .RESET_VALUE(4'h0)) dut (
        .CLK(clk), .RST(rst), .EN(en), .FLUSH(flush), .D(d), .VALID_IN(vin),
        .SEL(sel), .Q(q), .VALID_OUT(vout), .Q_LAST(q_last), .VALID_LAST(vlast),
        .OCCUPANCY(occ));

    dff_delay_line #(.WIDTH(4), .DEPTH(3), .RESET_VALUE(4'hC)) dut3 (
        .CLK(clk), .RST(rst3), .EN(en3), .FLUSH(flush3), .D(d3), .VALID_IN(vin3),
        .SEL(sel3), .Q(q3), .VALID_OUT(vout3), .Q_LAST(q_last3), .VALID_LAST(vlast3),
        .OCCUPANCY(occ3));

    typedef struct {
        logic       rst, flush, en, vin;
        logic [3:0] d;
        logic [1:0] sel;
        logic [3:0] eq;
        logic       ev;
        logic [3:0] eql;
        logic       evl;
        logic [2:0] eocc;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one edge; the scoreboard records captured samples and retires them
    // in order as they reach the last stage on an enabled edge.
    task automatic tick(input logic r, input logic f, input logic e,
                        input logic v, input logic [3:0] dd);
        logic [3:0] x;
        rst = r; flush = f; en = e; vin = v; d = dd;
        if (!r && !f && e && v) sb_q.push_back(dd);
        @(posedge clk); #1;
        if (r || f) begin
            sb_q.delete();
        end else if (e && vlast) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(vlast), 32'd0);
            end else begin
                x = sb_q.pop_front();
                chk("sb_q_last", 32'(q_last), 32'(x));
            end
        end
        chk("sb_depth", 32'(occ), 32'(sb_q.size() + int'(vlast)));
    endtask

    task automatic sweep_reset(input string name);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); #1;
            chk({name, "_q"}, 32'(q), 32'h0);
            chk({name, "_vout"}, 32'(vout), 32'd0);
        end
        chk({name, "_q_last"}, 32'(q_last), 32'h0);
        chk({name, "_vlast"}, 32'(vlast), 32'd0);
        chk({name, "_occ"}, 32'(occ), 32'd0);
    endtask

    task automatic popcount(output int pc);
        pc = 0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); #1;
            pc += int'(vout);
        end
    endtask

    function automatic vec_t mk(logic r, logic f, logic e, logic v, logic [3:0] dd,
                                logic [1:0] s, logic [3:0] eq, logic ev,
                                logic [3:0] eql, logic evl, logic [2:0] eocc);
        vec_t t;
        t.rst = r; t.flush = f; t.en = e; t.vin = v; t.d = dd; t.sel = s;
        t.eq = eq; t.ev = ev; t.eql = eql; t.evl = evl; t.eocc = eocc;
        return t;
    endfunction

    int pc;
    logic [3:0] bub_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] bub_o [4] = '{3'd1, 3'd1, 3'd2, 3'd3};

    initial begin
        // Stream 0..15 after reset: Q_LAST lags by DEPTH edges, occupancy saturates at 4.
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(0, 0, 1, 1, 4'(k), 2'd0, 4'(k), 1,
                             (k >= 3) ? 4'(k - 3) : 4'h0, (k >= 3),
                             (k >= 3) ? 3'd4 : 3'(k + 1)));
        // Stall with D=A: stages hold 15,14,13,12.
        tbl.push_back(mk(0, 0, 0, 1, 4'hA, 2'd0, 4'd15, 1, 4'd12, 1, 3'd4));
        tbl.push_back(mk(0, 0, 0, 1, 4'hA, 2'd1, 4'd14, 1, 4'd12, 1, 3'd4));
        tbl.push_back(mk(0, 0, 0, 1, 4'hA, 2'd3, 4'd12, 1, 4'd12, 1, 3'd4));
        // Flush with EN=1: data shifts, valids clear.
        tbl.push_back(mk(0, 1, 1, 1, 4'd5, 2'd0, 4'd5, 0, 4'd13, 0, 3'd0));
        tbl.push_back(mk(0, 0, 1, 1, 4'd6, 2'd0, 4'd6, 1, 4'd14, 0, 3'd1));
        tbl.push_back(mk(0, 0, 1, 0, 4'd7, 2'd1, 4'd6, 1, 4'd15, 0, 3'd1));
        tbl.push_back(mk(0, 0, 1, 1, 4'd8, 2'd0, 4'd8, 1, 4'd5, 0, 3'd2));
        tbl.push_back(mk(0, 0, 1, 0, 4'd9, 2'd3, 4'd6, 1, 4'd6, 1, 3'd2));
        tbl.push_back(mk(0, 0, 1, 1, 4'd3, 2'd2, 4'd8, 1, 4'd7, 0, 3'd2));
        tbl.push_back(mk(0, 0, 1, 1, 4'd4, 2'd3, 4'd8, 1, 4'd8, 1, 3'd3));
        tbl.push_back(mk(0, 0, 1, 1, 4'd5, 2'd1, 4'd4, 1, 4'd9, 0, 3'd3));
        tbl.push_back(mk(0, 0, 1, 1, 4'd6, 2'd0, 4'd6, 1, 4'd3, 1, 3'd4));
        // Full pipeline: one in, one out, occupancy unchanged.
        tbl.push_back(mk(0, 0, 1, 1, 4'd7, 2'd0, 4'd7, 1, 4'd4, 1, 3'd4));
        // Flush while stalled: data held, valids clear.
        tbl.push_back(mk(0, 1, 0, 1, 4'hB, 2'd0, 4'd7, 0, 4'd4, 0, 3'd0));

        // Reset held for two edges with live inputs.
        tick(1, 0, 1, 1, 4'hF);
        tick(1, 0, 1, 1, 4'hF);
        sweep_reset("reset");

        foreach (tbl[i]) begin
            sel = tbl[i].sel;
            tick(tbl[i].rst, tbl[i].flush, tbl[i].en, tbl[i].vin, tbl[i].d);
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].eq));
            chk($sformatf("vec%0d_vout", i), 32'(vout), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_q_last", i), 32'(q_last), 32'(tbl[i].eql));
            chk($sformatf("vec%0d_vlast", i), 32'(vlast), 32'(tbl[i].evl));
            chk($sformatf("vec%0d_occ", i), 32'(occ), 32'(tbl[i].eocc));
        end

        // Reset mid-stream beats FLUSH and EN on the same edge.
        for (int k = 1; k <= 4; k++) tick(0, 0, 1, 1, 4'(k));
        chk("refill_occ", 32'(occ), 32'd4);
        tick(1, 1, 1, 1, 4'hF);
        sweep_reset("midrst");

        // Bubble pattern: occupancy must track popcount of the valid taps.
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 1, bub_v[k], 4'(k + 1));
            chk($sformatf("bubble%0d_occ", k), 32'(occ), 32'(bub_o[k]));
            popcount(pc);
            chk($sformatf("bubble%0d_pop", k), 32'(pc), 32'(bub_o[k]));
        end
        en = 1'b0;

        // DEPTH=3 tap select including the out-of-range tap.
        rst3 = 1'b1; en3 = 1'b1; vin3 = 1'b1; d3 = 4'hF;
        @(posedge clk); #1;
        sel3 = 2'd0; #1;
        chk("d3_rst_q", 32'(q3), 32'hC);
        chk("d3_rst_occ", 32'(occ3), 32'd0);
        rst3 = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            d3 = 4'(k);
            @(posedge clk); #1;
        end
        en3 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel3 = 2'(s); #1;
            chk($sformatf("d3_tap%0d_q", s), 32'(q3), 32'(9 - s));
            chk($sformatf("d3_tap%0d_v", s), 32'(vout3), 32'd1);
        end
        sel3 = 2'd3; #1;
        chk("d3_tap3_q", 32'(q3), 32'hC);
        chk("d3_tap3_v", 32'(vout3), 32'd0);
        chk("d3_q_last", 32'(q_last3), 32'd7);
        chk("d3_occ", 32'(occ3), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
